// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: PC-1/PC-2 tables, shift schedule, widths
// and the 28-bit half-register rotate helper.
package des_pkg;

  localparam int KEY_W    = 64;
  localparam int HALF_W   = 28;
  localparam int CD_W     = 2 * HALF_W;
  localparam int SUBKEY_W = 48;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Entries are 1-based DES bit numbers, bit 1 being the MSB of the source.
  localparam int PC1 [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // SHIFTS[r-1] is the left-rotate amount used to produce C_r/D_r.
  localparam logic [1:0] SHIFTS [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [HALF_W-1:0] rot_half(
    input logic [HALF_W-1:0] x,
    input logic              left,
    input logic              two
  );
    logic [HALF_W-1:0] r;
    case ({left, two})
      2'b10:   r = {x[HALF_W-2:0], x[HALF_W-1]};
      2'b11:   r = {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]};
      2'b00:   r = {x[0], x[HALF_W-1:1]};
      default: r = {x[1:0], x[HALF_W-1:2]};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational DES PC-2 selection: 56-bit C||D in, 48-bit round subkey out.
module des_pc2
  import des_pkg::*;
(
  input  logic [CD_W-1:0]     i_cd,
  output logic [SUBKEY_W-1:0] o_subkey
);

  for (genvar gi = 0; gi < SUBKEY_W; gi++) begin : g_pc2
    assign o_subkey[SUBKEY_W-1-gi] = i_cd[CD_W-PC2[gi]];
  end

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: loads PC-1(key) into C/D and streams K1..K16
// (or K16..K1 for decryption) over a valid/ready handshake, one per transfer.
module des_key_schedule
  import des_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_valid,
  output logic                key_ready,
  input  logic [KEY_W-1:0]    key,
  input  logic                decrypt,
  output logic                subkey_valid,
  input  logic                subkey_ready,
  output logic [SUBKEY_W-1:0] subkey,
  output logic [3:0]          subkey_idx,
  output logic                subkey_last
);

  logic [0:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_decrypt;
  logic [HALF_W-1:0] r_c;
  logic [HALF_W-1:0] r_d;

  logic [CD_W-1:0]   w_pc1;
  logic [HALF_W-1:0] w_load_c;
  logic [HALF_W-1:0] w_load_d;
  logic [HALF_W-1:0] w_adv_c;
  logic [HALF_W-1:0] w_adv_d;
  logic [3:0]        w_sched_idx;
  logic              w_two;
  logic              w_unused_parity;

  for (genvar gi = 0; gi < CD_W; gi++) begin : g_pc1
    assign w_pc1[CD_W-1-gi] = key[KEY_W-PC1[gi]];
  end

  assign w_unused_parity = ^{key[56], key[48], key[40], key[32],
                             key[24], key[16], key[8],  key[0]};

  // C16/D16 equals C0/D0, so decryption starts from the unrotated PC-1.
  assign w_load_c = decrypt ? w_pc1[CD_W-1:HALF_W] : rot_half(w_pc1[CD_W-1:HALF_W], 1'b1, 1'b0);
  assign w_load_d = decrypt ? w_pc1[HALF_W-1:0]    : rot_half(w_pc1[HALF_W-1:0], 1'b1, 1'b0);

  // Encrypt steps forward with s[cnt+2]; decrypt undoes s[16-cnt].
  assign w_sched_idx = r_decrypt ? (4'd15 - r_cnt) : (r_cnt + 4'd1);
  assign w_two       = (SHIFTS[w_sched_idx] == 2'd2);
  assign w_adv_c     = rot_half(r_c, ~r_decrypt, w_two);
  assign w_adv_d     = rot_half(r_d, ~r_decrypt, w_two);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_decrypt <= 1'b0;
      r_c       <= '0;
      r_d       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (key_valid) begin
            r_state   <= ST_RUN;
            r_cnt     <= 4'd0;
            r_decrypt <= decrypt;
            r_c       <= w_load_c;
            r_d       <= w_load_d;
          end
        end
        default: begin
          if (subkey_ready) begin
            if (r_cnt == 4'd15) begin
              r_state <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt + 4'd1;
              r_c   <= w_adv_c;
              r_d   <= w_adv_d;
            end
          end
        end
      endcase
    end
  end

  assign key_ready    = (r_state == ST_IDLE);
  assign subkey_valid = (r_state == ST_RUN);
  assign subkey_last  = (r_state == ST_RUN) && (r_cnt == 4'd15);
  assign subkey_idx   = r_decrypt ? (4'd15 - r_cnt) : r_cnt;

  des_pc2 u_pc2 (
    .i_cd     ({r_c, r_d}),
    .o_subkey (subkey)
  );

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule using the classic 0x133457799BBCDFF1 key.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic        decrypt = 1'b0;
  logic        subkey_ready = 1'b0;
  logic [63:0] key = 64'h0;
  logic        key_ready;
  logic        subkey_valid;
  logic        subkey_last;
  logic [47:0] subkey;
  logic [3:0]  subkey_idx;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;

  // Hand-derived K1..K16 for KEY_A.
  logic [47:0] ek [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  always #5 clk = ~clk;

  des_key_schedule dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .key          (key),
    .decrypt      (decrypt),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .subkey       (subkey),
    .subkey_idx   (subkey_idx),
    .subkey_last  (subkey_last)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] exp_sk(input int pos, input logic dec, input logic zero);
    if (zero) return 48'h0;
    return dec ? ek[15-pos] : ek[pos];
  endfunction

  // Loads k, then checks n_xfer subkeys; optionally random backpressure and
  // a conflicting key held on the input while the sequence runs.
  task automatic run_seq(input logic [63:0] k, input logic dec, input logic zero,
                         input bit stall, input bit inject, input int n_xfer);
    int got = 0;
    int cyc = 0;
    logic [3:0] ei;
    @(negedge clk);
    chk("ready_before_load", 64'(key_ready), 64'd1);
    key          = k;
    decrypt      = dec;
    key_valid    = 1'b1;
    subkey_ready = 1'b0;
    @(posedge clk);
    while (got < n_xfer && cyc < 400) begin
      @(negedge clk);
      key_valid = inject;
      key       = 64'hFEDCBA9876543210;
      decrypt   = ~dec;
      ei = dec ? 4'(15 - got) : 4'(got);
      chk("subkey_valid", 64'(subkey_valid), 64'd1);
      chk("key_ready_run", 64'(key_ready), 64'd0);
      chk("subkey", 64'(subkey), 64'(exp_sk(got, dec, zero)));
      chk("subkey_idx", 64'(subkey_idx), 64'(ei));
      chk("subkey_last", 64'(subkey_last), 64'(got == 15));
      subkey_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (subkey_ready)
        $display("xfer dec=%0b pos=%0d idx=%0d subkey=%h last=%0b",
                 dec, got, subkey_idx, subkey, subkey_last);
      @(posedge clk);
      if (subkey_ready) got++;
      cyc++;
    end
    chk("xfer_count", 64'(got), 64'(n_xfer));
    if (!stall) chk("cycle_count", 64'(cyc), 64'(n_xfer));
    if (n_xfer == 16) begin
      @(negedge clk);
      key_valid    = 1'b0;
      subkey_ready = 1'b0;
      chk("key_ready_return", 64'(key_ready), 64'd1);
      chk("valid_idle", 64'(subkey_valid), 64'd0);
      chk("last_idle", 64'(subkey_last), 64'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_key_ready", 64'(key_ready), 64'd1);
    chk("rst_valid", 64'(subkey_valid), 64'd0);
    chk("rst_last", 64'(subkey_last), 64'd0);
    chk("rst_idx", 64'(subkey_idx), 64'd0);
    chk("rst_subkey", 64'(subkey), 64'd0);
    rst_n = 1'b1;

    run_seq(KEY_A, 1'b0, 1'b0, 1'b0, 1'b0, 16);
    run_seq(KEY_A, 1'b1, 1'b0, 1'b0, 1'b0, 16);
    run_seq(KEY_A, 1'b0, 1'b0, 1'b1, 1'b0, 16);
    run_seq(KEY_A, 1'b1, 1'b0, 1'b1, 1'b0, 16);
    run_seq(KEY_A, 1'b0, 1'b0, 1'b0, 1'b1, 16);
    run_seq(KEY_A, 1'b1, 1'b0, 1'b1, 1'b1, 16);

    run_seq(KEY_A, 1'b0, 1'b0, 1'b0, 1'b0, 7);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(subkey_valid), 64'd0);
    chk("midrst_key_ready", 64'(key_ready), 64'd1);
    chk("midrst_last", 64'(subkey_last), 64'd0);
    chk("midrst_idx", 64'(subkey_idx), 64'd0);
    chk("midrst_subkey", 64'(subkey), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_seq(KEY_A, 1'b0, 1'b0, 1'b0, 1'b0, 16);

    run_seq(64'h0000000000000000, 1'b0, 1'b1, 1'b0, 1'b0, 16);
    run_seq(64'h0101010101010101, 1'b0, 1'b1, 1'b0, 1'b0, 16);
    run_seq(64'h0101010101010101, 1'b1, 1'b1, 1'b1, 1'b0, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/des_key_schedule.md
# des_key_schedule

Iterative DES key-schedule generator. Accepts a 64-bit key, applies PC-1, and streams the sixteen 48-bit round subkeys, one per handshake, in encryption order (K1..K16) or decryption order (K16..K1). It sits directly upstream of the round datapath and drives its `subkey` input. An iterative core controller consumes one subkey per round.

## Interface
Parameters: none. All permutation tables and the shift schedule are fixed constants.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_valid`  in  1  `key`/`decrypt` are valid this cycle.
- `key_ready`  out  1  block can accept a new key; high exactly when the FSM is in IDLE.
- `key`  in  64  DES key; bit 63 is DES bit 1. Parity bits are ignored.
- `decrypt`  in  1  sampled with `key`. 0 selects order K1..K16; 1 selects K16..K1.
- `subkey_valid`  out  1  `subkey` holds a valid round key.
- `subkey_ready`  in  1  consumer accepts the current subkey.
- `subkey`  out  48  PC-2 output; bit 47 is PC-2 bit 1, so [47:42] feeds S-box 1.
- `subkey_idx`  out  4  DES round number minus 1 of the current subkey (0 for K1, 15 for K16).
- `subkey_last`  out  1  high with the 16th subkey of the sequence.

## Operation
- **FSM states:** IDLE, RUN.
- **IDLE:**
  - `key_ready` is 1.
  - When `key_valid` is 1, the block loads C/D (28 bits each) from PC-1(`key`), latches `decrypt`, and moves to RUN.
- **Encrypt load:** C/D is loaded as PC-1 rotated left by s1 (= 1), so the first emitted subkey is K1.
- **Decrypt load:** C/D is loaded as unrotated PC-1, because C16/D16 equals C0/D0. The first emitted subkey is therefore K16.
- **RUN:**
  - `subkey` = PC-2(C,D), computed combinationally from the C/D registers.
  - `subkey_valid` is 1.
  - The count `cnt` runs 0..15 and gives the position in the output sequence.
- **Advance:** on each accepted transfer (`subkey_valid` && `subkey_ready`) with `cnt` < 15, `cnt` increments and C/D rotate.
  - Encrypt: C/D rotate left by s[cnt+2].
  - Decrypt: C/D rotate right by s[16−cnt].
  - The shift schedule s[1..16] is 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. Rotations are 28-bit circular, applied independently to C and D.
- **Finish:** a transfer with `cnt` = 15 returns the FSM to IDLE. C/D and `cnt` are don't-care after this.
- **Index and last:**
  - Encrypt: `subkey_idx` = `cnt`.
  - Decrypt: `subkey_idx` = 15 − `cnt`.
  - `subkey_last` = (`cnt` == 15) in RUN.
- **Stall:** while `subkey_valid` && !`subkey_ready`, the outputs `subkey`, `subkey_idx` and `subkey_last` hold stable.
- **New key during RUN:** ignored. `key_ready` is 0 in RUN, and no abort path exists.
- **Idle outputs:** in IDLE, `subkey_valid` and `subkey_last` are 0. `subkey` and `subkey_idx` are don't-care.

## Timing
- **Reset:** asserting `rst_n` low at any time, including mid-sequence, forces:
  - FSM to IDLE, `cnt` = 0, C/D = 0;
  - outputs `key_ready` = 1, `subkey_valid` = 0, `subkey_last` = 0, `subkey_idx` = 0, `subkey` = PC-2(0) = 0.
- **Latency:** the key is accepted on edge N, and `subkey_valid` is 1 from cycle N+1.
- **Throughput:** with `subkey_ready` held at 1, sixteen subkeys appear on cycles N+1..N+16.
- **Back-to-back keys:** `key_ready` rises at N+17, so the next key is accepted no earlier than edge N+17. There is one bubble cycle between key sequences.
- **Handshake rules:**
  - `key_ready` does not depend combinationally on `key_valid`.
  - `subkey_valid` does not depend on `subkey_ready`.
  - No combinational path exists from `subkey_ready` to any output.

## Structure
- **Shared package `des_pkg`:**
  - PC-1 and PC-2 index tables;
  - 16-entry shift schedule;
  - width constants (`KEY_W` = 64, `HALF_W` = 28, `SUBKEY_W` = 48).
- **Sub-module `des_pc2`:** the pure combinational 56→48 permutation. It is reused by any future unrolled key schedule.
- **Top level:** the FSM, counter and C/D rotate registers live in `des_key_schedule`.

## Test plan
- **Encrypt, no stall:** reset, then `key` = 0x133457799BBCDFF1 with `decrypt` = 0 and `subkey_ready` = 1 → the first subkey is 0x1B02EFFC7072 (idx 0), the second is 0x79AED9DBC9E5 (idx 1), and the 16th is 0xCB3D8B0E17F5 (idx 15, `subkey_last` = 1). Exactly 16 valid cycles, and `key_ready` returns at N+17.
- **Decrypt:** same key with `decrypt` = 1 → the first subkey is 0xCB3D8B0E17F5 (idx 15), the second is K15 per the reference model, the last is 0x1B02EFFC7072 (idx 0, `subkey_last` = 1). All 16 values equal the encrypt sequence reversed.
- **Random stalls:** random `subkey_ready` backpressure → the sequence is identical to the no-stall case, and outputs are stable during every stall cycle.
- **Key ignored in RUN:** assert `key_valid` with a different key during RUN → no effect on the sequence. The key is accepted only after `key_ready` returns.
- **Reset mid-sequence:** pull `rst_n` low after the 7th subkey → `subkey_valid` = 0 and `key_ready` = 1 immediately. A fresh key then restarts cleanly from K1.
- **Parity insensitivity:** keys 0x0000000000000000 and 0x0101010101010101 (parity-only difference) → identical 16-subkey sequences, all zero.
